// File: rtl/req_delay_line.sv
// req_delay_line: per-channel request delay of 1..MAX_DELAY cycles with glitch-free retargeting; define REQ_DELAY_EDGE_CNT_EN to add outR edge counters
module req_delay_line #(
    parameter int CHANNELS  = 4,
    parameter int MAX_DELAY = 8,
    parameter int DSEL_W    = 3,
    parameter int CNT_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHANNELS-1:0]        inR,
    input  logic [DSEL_W-1:0]          dly_sel,
    output logic [CHANNELS-1:0]        outR,
    output logic [CHANNELS-1:0]        busy,
    output logic [CHANNELS*DSEL_W-1:0] tap_act
`ifdef REQ_DELAY_EDGE_CNT_EN
    ,
    output logic [CHANNELS*CNT_W-1:0]  edge_cnt
`endif
);
    localparam logic [DSEL_W-1:0] TAP_MAX = DSEL_W'(MAX_DELAY - 1);

    logic [MAX_DELAY-1:0] sr_q  [CHANNELS];
    logic [MAX_DELAY-1:0] sr_d  [CHANNELS];
    logic [DSEL_W-1:0]    tap_q [CHANNELS];
    logic [DSEL_W-1:0]    tap_d [CHANNELS];
    logic [DSEL_W-1:0]    tap_req;
    logic [CHANNELS-1:0]  commit;

    if (MAX_DELAY < 2 || (1 << DSEL_W) < MAX_DELAY || CNT_W < 1) begin : g_param_check
        $error("req_delay_line: invalid parameter combination");
    end

    always_comb begin
        tap_req = (dly_sel > TAP_MAX) ? TAP_MAX : dly_sel;
        busy    = '0;
        outR    = '0;
        tap_act = '0;
        commit  = '0;
        sr_d    = sr_q;
        tap_d   = tap_q;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int k = 1; k < MAX_DELAY; k++)
                if (k <= int'(tap_q[c]) && sr_q[c][k] != sr_q[c][0]) busy[c] = 1'b1;
            outR[c]                     = sr_q[c][tap_q[c]];
            tap_act[c*DSEL_W +: DSEL_W] = tap_q[c];
            // retarget only when the active window is flat and no new edge is entering
            commit[c] = tap_req != tap_q[c] && !busy[c] && inR[c] == sr_q[c][0];
            sr_d[c]   = commit[c] ? {MAX_DELAY{sr_q[c][0]}} : {sr_q[c][MAX_DELAY-2:0], inR[c]};
            tap_d[c]  = commit[c] ? tap_req : tap_q[c];
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            sr_q[c]  <= !rst ? '0 : sr_d[c];
            tap_q[c] <= !rst ? tap_req : tap_d[c];
        end
    end

`ifdef REQ_DELAY_EDGE_CNT_EN
    logic [CNT_W-1:0] cnt_q [CHANNELS];
    logic [CNT_W-1:0] cnt_d [CHANNELS];

    always_comb begin
        cnt_d    = cnt_q;
        edge_cnt = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            cnt_d[c]                     = cnt_q[c] + CNT_W'(sr_d[c][tap_d[c]] != outR[c]);
            edge_cnt[c*CNT_W +: CNT_W]   = cnt_q[c];
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++)
            cnt_q[c] <= !rst ? '0 : cnt_d[c];
    end
`endif
endmodule

// File: tb/tb_req_delay_line.sv
// tb_req_delay_line: directed vector table plus corner-case sequences for req_delay_line
module tb_req_delay_line;
    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic [3:0]  in_r  = '0;
    logic [2:0]  sel   = '0;
    logic [3:0]  out_r;
    logic [3:0]  busy;
    logic [11:0] tap;
    logic        rst6  = 1'b0;
    logic [0:0]  in6   = '0;
    logic [2:0]  sel6  = '0;
    logic [0:0]  out6;
    logic [0:0]  busy6;
    logic [2:0]  tap6;
`ifdef REQ_DELAY_EDGE_CNT_EN
    logic [31:0] edge_cnt;
    logic [7:0]  edge_cnt6;
`endif
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        r;
        logic [3:0]  i;
        logic [2:0]  s;
        logic [3:0]  o;
        logic [3:0]  b;
        logic [11:0] t;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    req_delay_line dut (
        .clk(clk), .rst(rst), .inR(in_r), .dly_sel(sel),
        .outR(out_r), .busy(busy), .tap_act(tap)
`ifdef REQ_DELAY_EDGE_CNT_EN
        , .edge_cnt(edge_cnt)
`endif
    );

    req_delay_line #(.CHANNELS(1), .MAX_DELAY(6), .DSEL_W(3), .CNT_W(8)) dut6 (
        .clk(clk), .rst(rst6), .inR(in6), .dly_sel(sel6),
        .outR(out6), .busy(busy6), .tap_act(tap6)
`ifdef REQ_DELAY_EDGE_CNT_EN
        , .edge_cnt(edge_cnt6)
`endif
    );

    task automatic add(input logic r, input logic [3:0] i, input logic [2:0] s,
                       input logic [3:0] o, input logic [3:0] b, input logic [11:0] t);
        vecs.push_back('{r, i, s, o, b, t});
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s #%0d: got 0x%0h, expected 0x%0h", name, idx, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        // reset and hold, then 3-cycle latency
        add(0, 4'hF, 2, 4'h0, 4'h0, 12'h492);
        add(0, 4'hF, 2, 4'h0, 4'h0, 12'h492);
        add(1, 4'hF, 2, 4'h0, 4'hF, 12'h492);
        add(1, 4'hF, 2, 4'h0, 4'hF, 12'h492);
        add(1, 4'hF, 2, 4'hF, 4'h0, 12'h492);
        // single pulse at D=1
        add(1, 4'hF, 0, 4'hF, 4'h0, 12'h000);
        add(1, 4'h0, 0, 4'h0, 4'h0, 12'h000);
        add(1, 4'h2, 0, 4'h2, 4'h0, 12'h000);
        add(1, 4'h0, 0, 4'h0, 4'h0, 12'h000);
        add(1, 4'h0, 0, 4'h0, 4'h0, 12'h000);
        // deferred retarget on ch0
        add(1, 4'h0, 5, 4'h0, 4'h0, 12'hB6D);
        add(1, 4'h1, 5, 4'h0, 4'h1, 12'hB6D);
        add(1, 4'h1, 1, 4'h0, 4'h1, 12'h24D);
        add(1, 4'h1, 1, 4'h0, 4'h1, 12'h24D);
        add(1, 4'h1, 1, 4'h0, 4'h1, 12'h24D);
        add(1, 4'h1, 1, 4'h0, 4'h1, 12'h24D);
        add(1, 4'h1, 1, 4'h1, 4'h0, 12'h24D);
        add(1, 4'h1, 1, 4'h1, 4'h0, 12'h249);
        add(1, 4'h0, 1, 4'h1, 4'h1, 12'h249);
        add(1, 4'h0, 1, 4'h0, 4'h0, 12'h249);
        // full-depth delay
        add(1, 4'h0, 7, 4'h0, 4'h0, 12'hFFF);
        for (int j = 0; j < 7; j++) add(1, 4'h1, 7, 4'h0, 4'h1, 12'hFFF);
        add(1, 4'h1, 7, 4'h1, 4'h0, 12'hFFF);
        // channel independence: ch2 toggles, ch3 idle
        add(1, 4'h1, 3, 4'h1, 4'h0, 12'h6DB);
        add(1, 4'h5, 3, 4'h1, 4'h4, 12'h6DB);
        add(1, 4'h1, 0, 4'h1, 4'h4, 12'h0C0);
        add(1, 4'h5, 0, 4'h1, 4'h4, 12'h0C0);
        add(1, 4'h1, 0, 4'h5, 4'h4, 12'h0C0);
        add(1, 4'h5, 0, 4'h1, 4'h4, 12'h0C0);
        add(1, 4'h5, 0, 4'h5, 4'h4, 12'h0C0);
        add(1, 4'h5, 0, 4'h1, 4'h4, 12'h0C0);
        add(1, 4'h5, 0, 4'h5, 4'h0, 12'h0C0);
        add(1, 4'h5, 0, 4'h5, 4'h0, 12'h000);
        // entering edge blocks commit, then mid-flight reset drops the edge
        add(1, 4'h0, 3, 4'h0, 4'h0, 12'h618);
        add(1, 4'h0, 3, 4'h0, 4'h0, 12'h6DB);
        add(1, 4'h1, 3, 4'h0, 4'h1, 12'h6DB);
        add(1, 4'h1, 3, 4'h0, 4'h1, 12'h6DB);
        add(0, 4'h1, 3, 4'h0, 4'h0, 12'h6DB);
        for (int j = 0; j < 5; j++) add(1, 4'h0, 3, 4'h0, 4'h0, 12'h6DB);

        for (int i = 0; i < vecs.size(); i++) begin
            rst  = vecs[i].r;
            in_r = vecs[i].i;
            sel  = vecs[i].s;
            tick();
            check("outR", i, 32'(out_r), 32'(vecs[i].o));
            check("busy", i, 32'(busy), 32'(vecs[i].b));
            check("tap_act", i, 32'(tap), 32'(vecs[i].t));
        end

        // saturation with MAX_DELAY=6
        rst6 = 1'b0; sel6 = 3'd7; in6 = 1'b0;
        tick();
        check("sat6_reset_tap", 0, 32'(tap6), 32'd5);
        sel6 = 3'd0;
        tick();
        check("sat6_reset_tap", 1, 32'(tap6), 32'd0);
        rst6 = 1'b1; sel6 = 3'd7;
        tick();
        check("sat6_commit_tap", 0, 32'(tap6), 32'd5);
        check("sat6_out_idle", 0, 32'(out6), 32'd0);
        in6 = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!out6 && n < 20);
        check("sat6_latency", 0, 32'(n), 32'd6);

`ifdef REQ_DELAY_EDGE_CNT_EN
        rst = 1'b0; in_r = 4'h0; sel = 3'd0;
        tick();
        check("edge_cnt_reset", 0, edge_cnt, 32'd0);
        rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            in_r = (j == 1) ? 4'h0 : 4'h1;
            tick();
        end
        check("edge_cnt_three", 0, edge_cnt, 32'd3);
        sel = 3'd3;
        tick();
        check("edge_cnt_commit_tap", 0, 32'(tap[2:0]), 32'd3);
        check("edge_cnt_commit_keep", 0, edge_cnt, 32'd3);
        in_r = 4'h0;
        tick();
        check("edge_cnt_inflight_busy", 0, 32'(busy), 32'd1);
        rst = 1'b0;
        tick();
        check("edge_cnt_midreset", 0, edge_cnt, 32'd0);
        check("edge_cnt_midreset_out", 0, 32'(out_r), 32'd0);
        rst = 1'b1;
        for (int j = 0; j < 6; j++) begin
            tick();
            check("edge_cnt_dropped", j, edge_cnt, 32'd0);
            check("edge_cnt_dropped_out", j, 32'(out_r), 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
